// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter:
// receiver state encoding, parity selectors and the 115200-baud divider.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } uart_rx_state_t;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  localparam int CLKS_PER_BIT_115200 = 87;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input; RESET_VAL is the level
// both stages take on reset (1 for an idle-high serial line).
module uart_sync #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta   <= RESET_VAL;
      o_Sync <= RESET_VAL;
    end else begin
      meta   <= i_Async;
      o_Sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with false-start rejection and frame/break detection.
// Define UART_RX_PARITY_EN to expect one parity bit (even/odd via PARITY_ODD) after the data.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = uart_pkg::PARITY_EVEN
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Rx_Busy
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_rx_state_t state, next_state;

  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 frame_err_acc;
  logic                 saw_one;
  logic                 sample;
  logic                 finish;
  logic                 brk_now;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_s)
  );

  // A break means no sample in the frame was high, including the final stop sample.
  assign brk_now   = ~saw_one & ~rx_s;
  assign o_Rx_Busy = (state != IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    sample     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) next_state = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          sample     = 1'b1;
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_LAST) begin
          sample = 1'b1;
          if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_LAST) begin
          sample     = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL_LAST) begin
          sample = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            finish     = 1'b1;
            next_state = brk_now ? BRK_WAIT : IDLE;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
`endif

  // Data arrives LSB first, so shifting in from the top leaves bit 0 at the bottom.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      data_sr       <= '0;
      frame_err_acc <= 1'b0;
      saw_one       <= 1'b0;
      o_Rx_DV       <= 1'b0;
      o_Rx_Byte     <= '0;
      o_Frame_Err   <= 1'b0;
      o_Break       <= 1'b0;
    end else begin
      o_Rx_DV     <= finish;
      o_Frame_Err <= finish & (frame_err_acc | ~rx_s);
      o_Break     <= finish & brk_now;
      if (finish) o_Rx_Byte <= data_sr;

      if (state == IDLE) begin
        clk_cnt       <= '0;
        bit_cnt       <= '0;
        frame_err_acc <= 1'b0;
        saw_one       <= 1'b0;
      end else if (sample) begin
        clk_cnt <= '0;
        if (state == DATA) begin
          data_sr <= {rx_s, data_sr[DATA_BITS-1:1]};
          saw_one <= saw_one | rx_s;
          bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end else if (state == STOP) begin
          frame_err_acc <= frame_err_acc | ~rx_s;
          saw_one       <= saw_one | rx_s;
          bit_cnt       <= bit_cnt + BIT_W'(1);
        end else if (state == PARITY) begin
          saw_one <= saw_one | rx_s;
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      parity_bit   <= 1'b0;
      o_Parity_Err <= 1'b0;
    end else begin
      if (state == PARITY && sample) parity_bit <= rx_s;
      o_Parity_Err <= finish & (parity_bit ^ (^data_sr) ^ PARITY_ODD);
    end
  end
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 instance and a 7-bit / 2-stop / odd
// instance receive directed and random frames; expectations come from a frame model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int CPB = 87;
  localparam int NB0 = 8;
  localparam int NB1 = 7;
  localparam int NS0 = 1;
  localparam int NS1 = 2;
  localparam bit ODD0 = 1'b0;
  localparam bit ODD1 = 1'b1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
  } exp_t;

  logic       r_Clock = 1'b0;
  logic       reset;
  logic [1:0] rxLine;

  logic       dv0, fe0, pe0, brk0, busy0;
  logic [7:0] byte0;
  logic       dv1, fe1, pe1, brk1, busy1;
  logic [6:0] byte1;

  exp_t expQ0[$];
  exp_t expQ1[$];
  exp_t e0, e1;
  int   tests = 0;
  int   fails = 0;
  int   flagViol = 0;
  logic prevDv0 = 1'b0;
  logic prevDv1 = 1'b0;

  always #50 r_Clock = ~r_Clock;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (NB0),
    .STOP_BITS    (NS0),
    .PARITY_ODD   (ODD0)
  ) dut0 (
    .i_Clock      (r_Clock),
    .i_Reset      (reset),
    .i_Rx_Serial  (rxLine[0]),
    .o_Rx_DV      (dv0),
    .o_Rx_Byte    (byte0),
    .o_Frame_Err  (fe0),
    .o_Parity_Err (pe0),
    .o_Break      (brk0),
    .o_Rx_Busy    (busy0)
  );

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (NB1),
    .STOP_BITS    (NS1),
    .PARITY_ODD   (ODD1)
  ) dut1 (
    .i_Clock      (r_Clock),
    .i_Reset      (reset),
    .i_Rx_Serial  (rxLine[1]),
    .o_Rx_DV      (dv1),
    .o_Rx_Byte    (byte1),
    .o_Frame_Err  (fe1),
    .o_Parity_Err (pe1),
    .o_Break      (brk1),
    .o_Rx_Busy    (busy1)
  );

  task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // What the receiver should report for a frame, derived from the frame contents.
  function automatic exp_t modelFrame(input int inst, input logic [8:0] data,
                                      input bit parFlip, input logic [1:0] stopLow);
    exp_t       e;
    logic [8:0] d;
    logic [1:0] smask;
    logic       parBit;
    bit         odd;
    d      = data & ((9'd1 << ((inst == 0) ? NB0 : NB1)) - 9'd1);
    smask  = (((inst == 0) ? NS0 : NS1) == 2) ? 2'b11 : 2'b01;
    odd    = (inst == 0) ? ODD0 : ODD1;
    parBit = (^d) ^ odd ^ parFlip;
    e.data = d;
    e.fe   = |(stopLow & smask);
    e.pe   = PAR_EN & parFlip;
    e.brk  = (d == 9'd0) && (!PAR_EN || !parBit) && ((stopLow & smask) == smask);
    return e;
  endfunction

  task automatic pushExp(input int inst, input exp_t e);
    if (inst == 0) expQ0.push_back(e);
    else           expQ1.push_back(e);
  endtask

  task automatic driveBit(input int inst, input logic val, input int n);
    rxLine[inst] = val;
    repeat (n) @(negedge r_Clock);
  endtask

  // A low stop bit is released early so the receiver does not mistake its tail for a start bit.
  task automatic applyStimulus(input int inst, input logic [8:0] data,
                               input bit parFlip, input logic [1:0] stopLow);
    exp_t e;
    int   nb, ns;
    bit   odd;
    nb  = (inst == 0) ? NB0 : NB1;
    ns  = (inst == 0) ? NS0 : NS1;
    odd = (inst == 0) ? ODD0 : ODD1;
    e   = modelFrame(inst, data, parFlip, stopLow);
    pushExp(inst, e);
    driveBit(inst, 1'b0, CPB);
    for (int i = 0; i < nb; i++) driveBit(inst, e.data[i], CPB);
    if (PAR_EN) driveBit(inst, (^e.data) ^ odd ^ parFlip, CPB);
    for (int s = 0; s < ns; s++) begin
      if (stopLow[s]) begin
        driveBit(inst, 1'b0, 60);
        driveBit(inst, 1'b1, CPB - 60);
      end else begin
        driveBit(inst, 1'b1, CPB);
      end
    end
    if (stopLow[ns-1]) driveBit(inst, 1'b1, CPB);
  endtask

  always @(negedge r_Clock) begin
    if (dv0 === 1'b1) begin
      if (expQ0.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_dv0: got DV with byte %0h, expected no DV", byte0);
      end else begin
        e0 = expQ0.pop_front();
        checkOutput("dut0 byte", {1'b0, byte0}, e0.data);
        checkOutput("dut0 frame_err", {8'd0, fe0}, {8'd0, e0.fe});
        checkOutput("dut0 parity_err", {8'd0, pe0}, {8'd0, e0.pe});
        checkOutput("dut0 break", {8'd0, brk0}, {8'd0, e0.brk});
      end
    end
    if (dv1 === 1'b1) begin
      if (expQ1.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_dv1: got DV with byte %0h, expected no DV", byte1);
      end else begin
        e1 = expQ1.pop_front();
        checkOutput("dut1 byte", {2'b0, byte1}, e1.data);
        checkOutput("dut1 frame_err", {8'd0, fe1}, {8'd0, e1.fe});
        checkOutput("dut1 parity_err", {8'd0, pe1}, {8'd0, e1.pe});
        checkOutput("dut1 break", {8'd0, brk1}, {8'd0, e1.brk});
      end
    end
    if ((dv0 === 1'b0) && ((fe0 | pe0 | brk0) === 1'b1)) flagViol++;
    if ((dv1 === 1'b0) && ((fe1 | pe1 | brk1) === 1'b1)) flagViol++;
    if ((prevDv0 === 1'b1) && (dv0 === 1'b1)) flagViol++;
    if ((prevDv1 === 1'b1) && (dv1 === 1'b1)) flagViol++;
    prevDv0 = dv0;
    prevDv1 = dv1;
  end

  initial begin
    #(95000 * 100);
    $display("[TB] FAIL watchdog: simulation still running at cycle 95000, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         waited;
    logic [8:0] rdata;
    logic [1:0] rstop;
    bit         rflip;

    reset  = 1'b1;
    rxLine = 2'b11;
    repeat (5) @(negedge r_Clock);
    checkOutput("reset dv0", {8'd0, dv0}, 9'd0);
    checkOutput("reset byte0", {1'b0, byte0}, 9'd0);
    checkOutput("reset busy0", {8'd0, busy0}, 9'd0);
    checkOutput("reset flags0", {6'd0, fe0, pe0, brk0}, 9'd0);
    checkOutput("reset byte1", {2'b0, byte1}, 9'd0);
    checkOutput("reset busy1", {8'd0, busy1}, 9'd0);
    reset = 1'b0;
    repeat (5) @(negedge r_Clock);

    // Back-to-back 8N1 frames.
    applyStimulus(0, 9'h03F, 1'b0, 2'b00);
    applyStimulus(0, 9'h0AB, 1'b0, 2'b00);
    driveBit(0, 1'b1, CPB);

    // Short low glitch must be rejected as a false start.
    driveBit(0, 1'b0, 20);
    rxLine[0] = 1'b1;
    checkOutput("glitch busy high", {8'd0, busy0}, 9'd1);
    waited = 0;
    while (busy0 !== 1'b0 && waited < 45) begin
      @(negedge r_Clock);
      waited++;
    end
    checkOutput("glitch busy released", {8'd0, busy0}, 9'd0);
    driveBit(0, 1'b1, CPB);

    // Line held low for 12 bit periods: a single break report.
    pushExp(0, modelFrame(0, 9'd0, ODD0, 2'b11));
    driveBit(0, 1'b0, 12 * CPB);
    checkOutput("break wait busy", {8'd0, busy0}, 9'd1);
    driveBit(0, 1'b1, 2 * CPB);
    applyStimulus(0, 9'h03F, 1'b0, 2'b00);

    // Parity good and bad (flag only expected when parity is compiled in).
    applyStimulus(0, 9'h0AB, 1'b0, 2'b00);
    applyStimulus(0, 9'h0AB, 1'b1, 2'b00);
    driveBit(0, 1'b1, CPB);

    // Reset pulse in the middle of data bit 3 of 0xF8 aborts the frame.
    driveBit(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) driveBit(0, 1'b0, CPB);
    driveBit(0, 1'b1, 40);
    reset = 1'b1;
    @(negedge r_Clock);
    reset = 1'b0;
    checkOutput("midframe reset dv0", {8'd0, dv0}, 9'd0);
    checkOutput("midframe reset byte0", {1'b0, byte0}, 9'd0);
    checkOutput("midframe reset busy0", {8'd0, busy0}, 9'd0);
    driveBit(0, 1'b1, (CPB - 41) + 5 * CPB);
    applyStimulus(0, 9'h05A, 1'b0, 2'b00);

    // 7-bit, 2-stop instance: clean frame, then second stop bit low.
    applyStimulus(1, 9'h055, 1'b0, 2'b00);
    applyStimulus(1, 9'h055, 1'b0, 2'b10);
    applyStimulus(1, 9'h02A, 1'b0, 2'b01);

    // Random frames on both instances.
    for (int n = 0; n < 28; n++) begin
      rdata = 9'($urandom);
      if ($urandom_range(0, 7) == 0) rdata = 9'd0;
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(n % 2, rdata, rflip, rstop);
      driveBit(n % 2, 1'b1, $urandom_range(0, CPB));
    end

    waited = 0;
    while ((expQ0.size() != 0 || expQ1.size() != 0) && waited < 4 * CPB) begin
      @(negedge r_Clock);
      waited++;
    end
    repeat (4 * CPB) @(negedge r_Clock);
    checkOutput("dut0 frames outstanding", 9'(expQ0.size()), 9'd0);
    checkOutput("dut1 frames outstanding", 9'(expQ1.size()), 9'd0);
    checkOutput("flags outside DV or wide DV", 9'(flagViol), 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
